writeback_arbiter: RTL
======================

Name: writeback_arbiter

Overview:
- Producer side of the physical register file write port: collects completed results from several functional units and drives the single register-file write port (WriteReg1/WriteData1/Write1).
- Buffers each unit's completions in a small per-source FIFO.
- Grants one write per cycle, round-robin, over a registered output.
- FLUSH discards all buffered results on pipeline recovery.

Parameters:
- NUM_PHYS_REGS, 64, physical register count; LOG_PHYS = $clog2(NUM_PHYS_REGS).
- NUM_SRC, 3, number of producing units (0 = ALU, 1 = MEM, 2 = MULDIV).
- DEPTH, 2, entries per source FIFO; power of two, at least 2.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous clear of all queued results.
- src_valid  in  NUM_SRC  per-source result valid.
- src_tag  in  NUM_SRC*LOG_PHYS  per-source destination physical register; source i occupies bits [i*LOG_PHYS +: LOG_PHYS].
- src_data  in  NUM_SRC*32  per-source result; source i occupies bits [i*32 +: 32].
- src_ready  out  NUM_SRC  per-source FIFO can accept.
- Write1  out  1  register-file write enable.
- WriteReg1  out  LOG_PHYS  register-file write address.
- WriteData1  out  32  register-file write data.
- Busy  out  1  any FIFO non-empty or Write1 asserted.

Behaviour:
- Reset (RESET low, asynchronous):
  - all FIFO pointers and counts = 0; round-robin pointer = 0.
  - Write1 = 0, WriteReg1 = 0, WriteData1 = 0.
  - src_ready = all ones; Busy = 0.
- Handshake: a transfer on source i occurs on a rising CLK edge when src_valid[i] && src_ready[i]. The FIFO captures tag and data.
- src_ready[i] = (count[i] != DEPTH). It is a function of state only, with no same-cycle dependence on dequeue.
  - A full FIFO does not accept in the cycle it is dequeued.
  - It accepts again in the following cycle.
- Arbitration, each cycle:
  - Candidates are the sources with non-empty FIFOs.
  - Search starts at rr_ptr and proceeds upward, modulo NUM_SRC.
  - The first candidate found is granted and its FIFO head is dequeued.
  - After a grant to source k, rr_ptr becomes (k+1) mod NUM_SRC.
  - rr_ptr is unchanged when nothing is granted.
- Output registered:
  - On a grant, next cycle Write1 = 1 and WriteReg1/WriteData1 = head entry.
  - Otherwise Write1 = 0; WriteReg1/WriteData1 hold their last values.
- Latency: a result accepted at edge t into an empty FIFO is granted in cycle t and appears on Write1 after edge t+1, i.e. 1 cycle minimum.
- Throughput: 1 write per cycle total.
- Simultaneous enqueue and dequeue on the same FIFO in one cycle is legal; count is unchanged.
- Tag 0:
  - A head entry with tag 0 is dequeued and consumes the grant.
  - The output Write1 stays 0, because physical register 0 is never written.
  - rr_ptr still advances.
- FLUSH high at an edge:
  - all FIFO counts and pointers = 0; next Write1 = 0.
  - Inputs presented in the same cycle are dropped, not enqueued.
  - rr_ptr is preserved.
- FIFO wrap-around: read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Busy = (|count) | Write1.
- Duplicate tags from different sources are legal; they are written in grant order.

Decomposition:
- Shared package/header `wb_pkg`:
  - LOG_PHYS derivation;
  - the source index constants (SRC_ALU = 0, SRC_MEM = 1, SRC_MULDIV = 2);
  - the 32-bit data width constant.
- One natural sub-module: `wb_src_fifo`, a DEPTH-entry synchronous FIFO with flush, count output, and tag+data payload. The top level instantiates NUM_SRC copies plus the round-robin arbiter and output register.

Test Plan:
- Reset mid-stream: fill ALU FIFO with 2 entries, pull RESET low mid-cycle → Write1 = 0 immediately, src_ready = 3'b111, Busy = 0. After release, no stale write appears.
- Single source latency: ALU valid, tag 6'd5, data 32'hDEADBEEF at edge t → after edge t+1: Write1 = 1, WriteReg1 = 5, WriteData1 = DEADBEEF. After edge t+2: Write1 = 0.
- Round-robin fairness: all three sources valid at the same edge with tags 1/2/3 → writes in order 1, 2, 3 on consecutive cycles. Next simultaneous batch tags 4/5/6 → order 4, 5, 6, because rr_ptr wrapped to 0.
- Backpressure: hold MEM valid with tags 10, 11, 12 while ALU keeps ALU winning priority → src_ready[1] drops to 0 after 2 accepts. Tag 12 is accepted only after MEM's head drains. All three are written exactly once, in order.
- Tag zero suppression: MULDIV presents tag 0, data 32'h1234 → no cycle with Write1 = 1 for it. A subsequent tag 7 is still written.
- Flush: queue ALU tags 8, 9 and MEM tag 20, assert FLUSH for one cycle → no writes for 8, 9, 20. Busy = 0 the cycle after. A new ALU tag 21 after FLUSH is written with 1-cycle latency.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared constants for the write-back arbiter slice.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int DATA_W     = 32;

    localparam int SRC_ALU    = 0;
    localparam int SRC_MEM    = 1;
    localparam int SRC_MULDIV = 2;

    // Tag width for a given physical register count (never narrower than 1 bit)
    function automatic int calcLogPhys(input int numPhysRegs);
        return (numPhysRegs > 1) ? $clog2(numPhysRegs) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_src_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_src_fifo
//  Description : DEPTH-entry tag+data FIFO with synchronous flush and count.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_src_fifo
    import wb_pkg::*;
#(
    parameter  int TAG_W = 6,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_flush,
    input  logic              i_pushValid,
    input  logic [TAG_W-1:0]  i_pushTag,
    input  logic [DATA_W-1:0] i_pushData,
    output logic              o_pushReady,
    input  logic              i_pop,
    output logic [TAG_W-1:0]  o_headTag,
    output logic [DATA_W-1:0] o_headData,
    output logic [PTR_W:0]    o_count
);

    logic [TAG_W+DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wrPtr;
    logic [PTR_W-1:0]        r_rdPtr;
    logic [PTR_W:0]          r_count;
    logic                    w_push;
    logic                    w_pop;

    // Readiness depends on state only, so a full FIFO cannot refill in its dequeue cycle
    assign o_pushReady = (r_count != (PTR_W+1)'(DEPTH));
    assign w_push      = i_pushValid && o_pushReady && !i_flush;
    assign w_pop       = i_pop && (r_count != '0) && !i_flush;
    assign o_count     = r_count;
    assign {o_headTag, o_headData} = r_mem[r_rdPtr];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wrPtr] <= {i_pushTag, i_pushData};
    end

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Round-robin arbiter feeding the single register-file write port.
//  Revision    : 1.0  initial release
// ============================================================================
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter  int NUM_PHYS_REGS = 64,
    parameter  int NUM_SRC       = 3,
    parameter  int DEPTH         = 2,
    localparam int LOG_PHYS      = calcLogPhys(NUM_PHYS_REGS)
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         FLUSH,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*LOG_PHYS-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic                         Write1,
    output logic [LOG_PHYS-1:0]          WriteReg1,
    output logic [DATA_W-1:0]            WriteData1,
    output logic                         Busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [LOG_PHYS-1:0] w_headTag  [NUM_SRC];
    logic [DATA_W-1:0]   w_headData [NUM_SRC];
    logic [PTR_W:0]      w_count    [NUM_SRC];
    logic [NUM_SRC-1:0]  w_nonEmpty;
    logic [NUM_SRC-1:0]  w_pop;

    logic [SRC_W-1:0]    r_rrPtr;
    logic [SRC_W-1:0]    w_rrNext;
    logic [SRC_W-1:0]    w_cand;
    logic [SRC_W-1:0]    w_grantIdx;
    logic                w_grant;
    logic [LOG_PHYS-1:0] w_grantTag;
    logic [DATA_W-1:0]   w_grantData;

    logic                r_write;
    logic [LOG_PHYS-1:0] r_writeReg;
    logic [DATA_W-1:0]   r_writeData;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            wb_src_fifo #(
                .TAG_W (LOG_PHYS),
                .DEPTH (DEPTH)
            ) u_fifo (
                .CLK         (CLK),
                .RESET       (RESET),
                .i_flush     (FLUSH),
                .i_pushValid (src_valid[i]),
                .i_pushTag   (src_tag[i*LOG_PHYS +: LOG_PHYS]),
                .i_pushData  (src_data[i*DATA_W +: DATA_W]),
                .o_pushReady (src_ready[i]),
                .i_pop       (w_pop[i]),
                .o_headTag   (w_headTag[i]),
                .o_headData  (w_headData[i]),
                .o_count     (w_count[i])
            );
            assign w_nonEmpty[i] = (w_count[i] != '0);
            assign w_pop[i]      = w_grant && (w_grantIdx == SRC_W'(i));
        end
    endgenerate

    // First non-empty source at or above the round-robin pointer, wrapping
    always_comb begin
        w_grant    = 1'b0;
        w_grantIdx = '0;
        w_cand     = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            w_cand = SRC_W'((int'(r_rrPtr) + off) % NUM_SRC);
            if (!w_grant && w_nonEmpty[w_cand]) begin
                w_grant    = 1'b1;
                w_grantIdx = w_cand;
            end
        end
    end

    assign w_rrNext    = (w_grantIdx == SRC_W'(NUM_SRC-1)) ? '0 : w_grantIdx + 1'b1;
    assign w_grantTag  = w_headTag[w_grantIdx];
    assign w_grantData = w_headData[w_grantIdx];

    // Tag 0 consumes its grant but never reaches the register file
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rrPtr     <= '0;
            r_write     <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
        end else if (FLUSH) begin
            r_write     <= 1'b0;
        end else begin
            r_write <= w_grant && (w_grantTag != '0);
            if (w_grant && (w_grantTag != '0)) begin
                r_writeReg  <= w_grantTag;
                r_writeData <= w_grantData;
            end
            if (w_grant) r_rrPtr <= w_rrNext;
        end
    end

    assign Write1     = r_write;
    assign WriteReg1  = r_writeReg;
    assign WriteData1 = r_writeData;
    assign Busy       = (|w_nonEmpty) | r_write;

endmodule
`default_nettype wire
